lut_gate_filtered: RTL and testbench
====================================

Name: lut_gate_filtered

Overview:
- Parametrised N-input programmable logic gate for the 3-input circuit library, generalising the fixed truth-table gate modules.
- The truth table is loaded at run time through a serial configuration port and committed atomically.
- The output passes through a persistence filter: it changes only after the new logic value has held for DELAY consecutive cycles. This models expression delay and suppresses glitches.
- Used as the clocked, reconfigurable gate primitive in synthesised circuit netlists.

Parameters:
- N_IN, 3, number of logic inputs (1..6); table width TW = 2^N_IN.
- DELAY, 4, consecutive cycles a differing value must persist before the output updates (>=1).
- TT_INIT, 0, TW-bit truth table loaded into the active table at reset.
- OUT_INIT, 1'b0, output value at reset.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous active-high reset
- in  in  N_IN  logic inputs; index = in with in[N_IN-1] as MSB
- cfg_en  in  1  configuration shift enable
- cfg_bit  in  1  serial table bit, entry TW-1 first
- cfg_done  out  1  one-cycle pulse; new table committed
- out  out  1  filtered gate output
- busy  out  1  high while a pending change is being counted

Behaviour:
Reset (async, rst=1):
- active table = TT_INIT; shadow = 0; bit counter = 0; filter counter = 0.
- out = OUT_INIT; cfg_done = 0; busy = 0.
- Applies immediately, including mid-load and mid-filter.
- A partial load is discarded; no commit occurs.

Configuration:
- Each cycle with cfg_en=1: shadow <= {shadow[TW-2:0], cfg_bit}; bit counter increments.
- When the bit counter is at TW-1 and cfg_en=1:
  - active table <= {shadow[TW-2:0], cfg_bit};
  - bit counter wraps to 0;
  - cfg_done=1 for the next cycle only.
- cfg_en=0: shadow and bit counter hold. Gaps between bits are legal.
- The active table changes only on commit; the logic path never sees a partial table.
- Back-to-back loads are allowed. cfg_done pulses once per TW accepted bits.

Logic and filter:
- f = active_table[in], combinational from the registered table and the live inputs.
- If f == out: filter counter <= 0.
- Else if counter == DELAY-1: out <= f; counter <= 0.
- Else: counter <= counter + 1.
- Resulting latency:
  - A stable input change is visible on out exactly DELAY cycles after the first edge where f differs.
  - DELAY=1 gives a plain one-cycle registered output.
- Glitch rule: any cycle with f == out during counting clears the counter. A pulse shorter than DELAY cycles never reaches out.
- Counter width is clog2(DELAY), minimum 1 bit. It never exceeds DELAY-1.
- busy = (counter != 0), registered.

Simultaneous events:
- A table commit during counting does not clear the counter. The next cycle evaluates f with the new table.
  - If the new f equals out, the counter clears.
  - If it still differs, counting continues from the current value.
- An input change and a commit on the same edge are both honoured; f uses the new inputs and the old table that cycle.

Test Plan:
1. Reset value: N_IN=3, DELAY=4, TT_INIT=8'hE2, OUT_INIT=0, in=3'b000, assert rst mid-cycle -> out=0, busy=0, cfg_done=0 asynchronously. After release, out rises to 1 (entry 0 = 0? no: bit0 of 0xE2 = 0, so out stays 0). Then set in=3'b001 (bit1=1) -> busy high for cycles 1-3 and out=1 at the 4th rising edge.
2. Glitch rejection: from out=1, in=3'b001, drive in=3'b011 (entry 3 = 0) for 3 cycles, then back to 3'b001 -> out stays 1 throughout and the counter returns to 0. Hold 3'b011 for 4 cycles -> out=0 on the 4th edge.
3. Serial load: shift bits 1,0,0,1,0,1,1,0 with cfg_en=1, including a 2-cycle cfg_en=0 gap after the 3rd bit -> single cfg_done pulse after the 8th bit, table=8'h96 (XOR3). in=3'b111 -> out=1 after 4 cycles; in=3'b110 -> out=0 after 4 cycles.
4. Reset mid-load: shift 5 bits, pulse rst, then shift 8 bits of 0x0F -> exactly one cfg_done pulse, table=8'h0F, never 8'hE2-derived.
5. Commit during count: out=0, f=1 counting at counter=2; commit a table where f=0 -> counter clears, out stays 0. Repeat with a table where f=1 -> out=1 one cycle later (counter continues 2->3 then updates).
6. DELAY=1 sweep: all 8 inputs with table 8'hA5 -> out equals the table entry exactly one cycle after each input change.

Source files
------------

// File: rtl/lut_gate_filtered.sv
// lut_gate_filtered: N-input programmable gate. The truth table is loaded
// serially into a shadow register and committed atomically into the active
// table. The gate value is then passed through a persistence filter, so the
// output only moves once a new value has held for DELAY consecutive cycles.
module lut_gate_filtered #(
   parameter int                     N_IN     = 3,
   parameter int                     DELAY    = 4,
   parameter logic [(1<<N_IN)-1:0]   TT_INIT  = '0,
   parameter logic                   OUT_INIT = 1'b0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N_IN-1:0] in,
   input  logic            cfg_en,
   input  logic            cfg_bit,
   output logic            cfg_done,
   output logic            out,
   output logic            busy
);

   localparam int TW = 1 << N_IN;
   localparam int BW = N_IN;
   localparam int CW = (DELAY > 1) ? $clog2(DELAY) : 1;
   localparam logic [BW-1:0] BIT_LAST = BW'(TW - 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DELAY - 1);

   // Only TW-1 bits of shadow history ever matter: the newest bit arrives
   // on cfg_bit in the same cycle the table is committed.
   logic [TW-1:0] tt_q;
   logic [TW-2:0] shadow_q;
   logic [TW-1:0] shadow_next;
   logic [BW-1:0] bit_cnt_q;

   logic          f;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic          out_d;

   assign shadow_next = {shadow_q, cfg_bit};

   // Serial load: shift bits in, commit the full table on the TW-th bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tt_q      <= TT_INIT;
         shadow_q  <= '0;
         bit_cnt_q <= '0;
         cfg_done  <= 1'b0;
      end else begin
         cfg_done <= 1'b0;
         if (cfg_en) begin
            shadow_q <= shadow_next[TW-2:0];
            if (bit_cnt_q == BIT_LAST) begin
               tt_q      <= shadow_next;
               bit_cnt_q <= '0;
               cfg_done  <= 1'b1;
            end else begin
               bit_cnt_q <= bit_cnt_q + BW'(1);
            end
         end
      end
   end

   // Gate value from the committed table and the live inputs.
   assign f = tt_q[in];

   // Persistence filter: count cycles of disagreement, update on the last.
   always_comb begin
      cnt_d = cnt_q;
      out_d = out;
      if (f == out) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         out_d = f;
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // Filter state; busy tracks a nonzero counter without a combinational path.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         out   <= OUT_INIT;
         busy  <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         out   <= out_d;
         busy  <= (cnt_d != '0);
      end
   end

endmodule

// File: tb/tb_lut_gate_filtered.sv
// Directed bench for lut_gate_filtered: a DELAY=4 instance for reset, filter,
// load and commit-during-count behaviour, and a DELAY=1 instance for the sweep.
module tb_lut_gate_filtered;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] in;
   logic       cfg_en, cfg_bit;
   logic       cfg_done, out, busy;

   logic [2:0] in1;
   logic       cfg_en1, cfg_bit1;
   logic       cfg_done1, out1, busy1;

   int total = 0;
   int bad   = 0;
   int done_cnt;
   logic [7:0] tt_a5 = 8'hA5;
   logic [7:0] tt_0f = 8'h0F;
   logic       prev1;

   lut_gate_filtered #(.N_IN(3), .DELAY(4), .TT_INIT(8'hE2), .OUT_INIT(1'b0)) u_dut (
      .clk(clk), .rst(rst), .in(in), .cfg_en(cfg_en), .cfg_bit(cfg_bit),
      .cfg_done(cfg_done), .out(out), .busy(busy)
   );

   lut_gate_filtered #(.N_IN(3), .DELAY(1), .TT_INIT(8'hA5), .OUT_INIT(1'b0)) u_dut1 (
      .clk(clk), .rst(rst), .in(in1), .cfg_en(cfg_en1), .cfg_bit(cfg_bit1),
      .cfg_done(cfg_done1), .out(out1), .busy(busy1)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic shift_bit(input logic b);
      cfg_en  = 1'b1;
      cfg_bit = b;
      tick();
      cfg_en  = 1'b0;
   endtask

   initial begin
      rst = 1'b1; in = 3'b000; cfg_en = 1'b0; cfg_bit = 1'b0;
      in1 = 3'b000; cfg_en1 = 1'b0; cfg_bit1 = 1'b0;

      // 1: reset values, then a stable change appears after 4 edges
      #1;
      chk("rst_out", out, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", cfg_done, 1'b0);
      chk("rst_out1", out1, 1'b0);
      #7 rst = 1'b0;
      tick();
      chk("t1_idle_out", out, 1'b0);
      chk("t1_idle_busy", busy, 1'b0);
      in = 3'b001;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t1_cnt_busy", busy, 1'b1);
         chk("t1_cnt_out", out, 1'b0);
      end
      tick();
      chk("t1_upd_out", out, 1'b1);
      chk("t1_upd_busy", busy, 1'b0);

      // 2: a 3-cycle glitch is rejected, a 4-cycle hold passes
      in = 3'b011;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t2_glitch_out", out, 1'b1);
         chk("t2_glitch_busy", busy, 1'b1);
      end
      in = 3'b001;
      tick();
      chk("t2_clear_out", out, 1'b1);
      chk("t2_clear_busy", busy, 1'b0);
      in = 3'b011;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t2_hold_out", out, 1'b1);
      end
      tick();
      chk("t2_hold_upd", out, 1'b0);
      chk("t2_hold_busy", busy, 1'b0);

      // asynchronous reset in the middle of a count, with out high
      in = 3'b001;
      repeat (4) tick();
      chk("ar_pre_out", out, 1'b1);
      in = 3'b011;
      repeat (2) tick();
      chk("ar_pre_busy", busy, 1'b1);
      #3 rst = 1'b1;
      #1;
      chk("ar_out", out, 1'b0);
      chk("ar_busy", busy, 1'b0);
      chk("ar_done", cfg_done, 1'b0);
      in = 3'b000;
      #2 rst = 1'b0;

      // 3: serial load of 0x96 with a gap after the third bit
      shift_bit(1'b1); chk("t3_b1", cfg_done, 1'b0);
      shift_bit(1'b0); chk("t3_b2", cfg_done, 1'b0);
      shift_bit(1'b0); chk("t3_b3", cfg_done, 1'b0);
      repeat (2) begin
         tick();
         chk("t3_gap", cfg_done, 1'b0);
      end
      shift_bit(1'b1); chk("t3_b4", cfg_done, 1'b0);
      shift_bit(1'b0); chk("t3_b5", cfg_done, 1'b0);
      shift_bit(1'b1); chk("t3_b6", cfg_done, 1'b0);
      shift_bit(1'b1); chk("t3_b7", cfg_done, 1'b0);
      shift_bit(1'b0); chk("t3_b8_done", cfg_done, 1'b1);
      tick();
      chk("t3_done_pulse", cfg_done, 1'b0);
      in = 3'b111;
      repeat (3) tick();
      chk("t3_111_wait", out, 1'b0);
      tick();
      chk("t3_111_out", out, 1'b1);
      in = 3'b110;
      repeat (3) tick();
      chk("t3_110_wait", out, 1'b1);
      tick();
      chk("t3_110_out", out, 1'b0);

      // 4: reset discards a partial load; a full 0x0F load commits once
      in = 3'b000;
      done_cnt = 0;
      repeat (5) begin
         shift_bit(1'b1);
         if (cfg_done) done_cnt++;
      end
      #3 rst = 1'b1;
      #1 chk("t4_rst_done", cfg_done, 1'b0);
      #1 rst = 1'b0;
      for (int i = 7; i >= 0; i--) begin
         shift_bit(tt_0f[i]);
         if (cfg_done) done_cnt++;
      end
      chk("t4_last_done", cfg_done, 1'b1);
      tick();
      if (cfg_done) done_cnt++;
      chk("t4_one_pulse", done_cnt == 1, 1'b1);
      chk("t4_count_busy", busy, 1'b1);
      repeat (2) tick();
      chk("t4_wait_out", out, 1'b0);
      tick();
      chk("t4_e0_out", out, 1'b1);
      in = 3'b100;
      repeat (4) tick();
      chk("t4_e4_out", out, 1'b0);
      chk("t4_e4_busy", busy, 1'b0);

      // 5a: commit of 0xF0 at counter=2 makes f agree with out -> counter clears
      shift_bit(1'b1); shift_bit(1'b1); shift_bit(1'b1); shift_bit(1'b1);
      shift_bit(1'b0); shift_bit(1'b0); shift_bit(1'b0);
      chk("t5a_no_done", cfg_done, 1'b0);
      in = 3'b000;
      repeat (2) tick();
      chk("t5a_cnt_busy", busy, 1'b1);
      chk("t5a_cnt_out", out, 1'b0);
      shift_bit(1'b0);
      chk("t5a_commit_done", cfg_done, 1'b1);
      chk("t5a_commit_busy", busy, 1'b1);
      chk("t5a_commit_out", out, 1'b0);
      tick();
      chk("t5a_clear_busy", busy, 1'b0);
      chk("t5a_clear_out", out, 1'b0);
      tick();
      chk("t5a_stay_out", out, 1'b0);

      // 5b: commit of 0x3C at counter=2 keeps f differing -> update next edge
      shift_bit(1'b0); shift_bit(1'b0); shift_bit(1'b1); shift_bit(1'b1);
      shift_bit(1'b1); shift_bit(1'b1); shift_bit(1'b0);
      in = 3'b100;
      repeat (2) tick();
      chk("t5b_cnt_busy", busy, 1'b1);
      shift_bit(1'b0);
      chk("t5b_commit_done", cfg_done, 1'b1);
      chk("t5b_commit_out", out, 1'b0);
      chk("t5b_commit_busy", busy, 1'b1);
      tick();
      chk("t5b_upd_out", out, 1'b1);
      chk("t5b_upd_busy", busy, 1'b0);
      in = 3'b000;
      repeat (4) tick();
      chk("t5b_e0_out", out, 1'b0);

      // 6: DELAY=1 sweep over table 0xA5
      prev1 = tt_a5[0];
      for (int i = 0; i < 8; i++) begin
         in1 = 3'(i);
         #1 chk("t6_no_comb", out1, prev1);
         tick();
         chk("t6_out", out1, tt_a5[i]);
         chk("t6_busy", busy1, 1'b0);
         prev1 = tt_a5[i];
      end
      chk("t6_done", cfg_done1, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Safety bound so the run always terminates.
   initial begin
      #100000;
      bad++;
      $display("FAIL timeout: got no finish expected finish");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
